plot_ctrl: RTL and testbench
============================

# plot_ctrl

Downstream stage of the etch-a-sketch datapath. Consumes the cursor position (`xpos`/`ypos`) and pen colour and turns them into single-cycle pixel writes for the VGA frame-buffer adapter. On request it also clears the canvas with a full raster sweep in the background colour, then redraws the cursor. All outputs are registered, and at most one pixel is written per clock.

## Interface
- `WIDTH`, default 160: canvas width in pixels. Valid x is 0..WIDTH-1.
- `HEIGHT`, default 120: canvas height in pixels. Valid y is 0..HEIGHT-1.
- `BG_COLOUR`, default 3'b000: colour written during a clear.
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `xpos`  in  8  cursor x from the datapath.
- `ypos`  in  8  cursor y from the datapath.
- `colour_in`  in  3  pen colour.
- `clear_req`  in  1  level or pulse; requests a canvas clear.
- `vga_x`  out  8  pixel x to the adapter.
- `vga_y`  out  7  pixel y to the adapter.
- `vga_colour`  out  3  pixel colour.
- `vga_plot`  out  1  write strobe. One pixel is written per high cycle.
- `busy`  out  1  high while the block is in CLEAR or DONE.
- `clear_done`  out  1  one-cycle pulse at the end of a clear.

## Operation
- FSM states: IDLE, CLEAR, DONE.
- **Reset:**
  - All outputs are 0 and the state is IDLE.
  - `last_x`/`last_y` are cleared and the `redraw` flag is set.
- **IDLE:**
  - If `clear_req`=1, go to CLEAR. Clear has priority over a simultaneous position change.
  - Otherwise, if `redraw`=1 or (`xpos`,`ypos`) differs from (`last_x`,`last_y`):
    - If `xpos`<WIDTH and `ypos`<HEIGHT: issue one plot with `colour_in`, then update `last_x`/`last_y` and clear `redraw`.
    - If out of range: no plot. `last_x`/`last_y` are still updated, so the same out-of-range position does not retrigger.
- **CLEAR:**
  - Raster sweep: x is the inner counter 0..WIDTH-1, y is the outer counter 0..HEIGHT-1.
  - `vga_plot`=1 every cycle with colour BG_COLOUR, for WIDTH×HEIGHT cycles.
  - Position changes and `clear_req` are ignored. A clear is never restarted.
  - After pixel (WIDTH-1, HEIGHT-1), go to DONE.
- **DONE (one cycle):**
  - `clear_done`=1.
  - `vga_plot`=1 at the current (`xpos`,`ypos`) with `colour_in`, only if that position is in range.
  - Update `last_x`/`last_y`, clear `redraw`, then go to IDLE.
- **Width rules:**
  - `vga_y` is `ypos[6:0]`, taken only after the range check passes.
  - Sweep counters are sized by $clog2 of WIDTH and HEIGHT. They never wrap mid-sweep.
- **Reset during CLEAR:** the sweep aborts immediately and no `clear_done` is issued.

## Timing
- Inputs are sampled at edge N. The plot outputs are valid during cycle N+1, so latency is 1 cycle.
- A cursor move produces exactly one `vga_plot` cycle. Back-to-back moves on consecutive cycles produce back-to-back plots.
- Clear timeline, with `clear_req` sampled at edge N while in IDLE:
  - First clear pixel (0,0) at N+1.
  - Last clear pixel (159,119) at N+19200.
  - DONE cycle (`clear_done` plus cursor redraw) at N+19201.
- `busy` is high from N+1 through N+19201 inclusive.
- After the cycle in which reset is deasserted, the next cycle plots the current cursor (`redraw`).

## Configuration
- Macro: `PLOT_CTRL_CLEAR_ON_RESET_EN`.
- **Defined:** leaving reset enters CLEAR instead of IDLE. A full sweep and DONE follow, so the screen is blank with the cursor drawn. `busy` is high from the first post-reset cycle.
- **Undefined:** leaving reset enters IDLE. Only the cursor redraw occurs, and the prior screen contents are untouched.

## Structure
- Shared package `plot_pkg` holds:
  - the state enum (IDLE, CLEAR, DONE);
  - the default canvas constants CANVAS_W=160 and CANVAS_H=120;
  - the colour width constant COLOUR_W=3.
- The datapath's `max_x`/`max_y` are sourced from the same package constants.
- One sub-module, `raster_counter`:
  - parameterised x/y counter with `en`, `start` and `last` outputs;
  - used for the clear sweep.

## Test plan
- **Reset release, no macro:** cursor at (5,7), colour 3'b100. Expect exactly one plot at (5,7) colour 3'b100 one cycle after reset release, then `vga_plot` stays low.
- **Move:** (5,7) changes to (6,7). Expect one plot at (6,7) on the next cycle. Holding (6,7) produces no further plots.
- **Out of range:** `xpos`=160 or `ypos`=120. Expect no plot. Returning to (159,119) produces a plot.
- **Clear:** `clear_req` pulse at cycle N.
  - Expect 19200 plots with colour 3'b000, first (0,0) at N+1, last (159,119) at N+19200.
  - Expect `clear_done` plus a cursor plot at N+19201.
  - `busy` covers exactly that window.
- **Move and clear_req mid-sweep:** cursor goes to (40,30) and `clear_req` is re-asserted during the sweep. Expect the sweep to be uninterrupted, no restart, and the DONE-cycle plot at (40,30).
- **Reset at sweep pixel 1000:** expect outputs 0 on the next cycle, no `clear_done`, and a cursor redraw. With `PLOT_CTRL_CLEAR_ON_RESET_EN` defined, expect a full new sweep instead.

Source files
------------

// File: rtl/plot_pkg.sv
// plot_pkg
// Shared definitions for the plot controller slice: the controller state
// enum, the default canvas dimensions and the pen colour width. The canvas
// constants are also what the upstream datapath uses for its max_x/max_y,
// so both sides agree on the drawable area.
package plot_pkg;

  localparam int CANVAS_W = 160;
  localparam int CANVAS_H = 120;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } plot_state_e;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plot_ctrl_raster_counter.sv
// raster_counter
// Row-major x/y counter used to sweep the whole canvas. x is the inner
// counter (0..W-1) and y the outer counter (0..H-1).
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset, returns the count to (0,0)
//   start  in   synchronous reload to (0,0); wins over en
//   en     in   advance one pixel
//   x      out  current x position
//   y      out  current y position
//   last   out  high while the count sits on (W-1, H-1)
module raster_counter
  import plot_pkg::*;
#(
  parameter int W = CANVAS_W,
  parameter int H = CANVAS_H
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    en,
  output logic [cnt_width(W)-1:0] x,
  output logic [cnt_width(H)-1:0] y,
  output logic                    last
);

  localparam int XW = cnt_width(W);
  localparam int YW = cnt_width(H);
  localparam logic [XW-1:0] XMAX = XW'(W - 1);
  localparam logic [YW-1:0] YMAX = YW'(H - 1);

  assign last = (x == XMAX) && (y == YMAX);

  // The counter wraps back to (0,0) after the final pixel so it is ready
  // for the next sweep without needing an explicit start.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == XMAX) begin
        x <= '0;
        if (y == YMAX) begin
          y <= '0;
        end else begin
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_ctrl.sv
// plot_ctrl
// Turns the cursor position and pen colour into single-cycle pixel writes
// for the VGA frame-buffer adapter. A clear request sweeps the whole canvas
// in BG_COLOUR and then redraws the cursor. All outputs are registered.
//
// Configuration macro: PLOT_CTRL_CLEAR_ON_RESET_EN
//   defined   - leaving reset starts a full clear sweep
//   undefined - leaving reset only redraws the cursor
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   xpos, ypos  in   cursor position from the datapath
//   colour_in   in   pen colour
//   clear_req   in   canvas clear request (level or pulse)
//   vga_x/y     out  pixel coordinates to the adapter
//   vga_colour  out  pixel colour
//   vga_plot    out  write strobe, one pixel per high cycle
//   busy        out  high while clearing or finishing a clear
//   clear_done  out  one-cycle pulse at the end of a clear
module plot_ctrl
  import plot_pkg::*;
#(
  parameter int                   WIDTH     = CANVAS_W,
  parameter int                   HEIGHT    = CANVAS_H,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          xpos,
  input  logic [7:0]          ypos,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                clear_req,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                clear_done
);

  localparam int CXW = cnt_width(WIDTH);
  localparam int CYW = cnt_width(HEIGHT);

`ifdef PLOT_CTRL_CLEAR_ON_RESET_EN
  localparam plot_state_e RESET_STATE = CLEAR;
`else
  localparam plot_state_e RESET_STATE = IDLE;
`endif

  plot_state_e         state, state_next;
  logic [7:0]          last_x, last_x_next;
  logic [7:0]          last_y, last_y_next;
  logic                redraw, redraw_next;
  logic [7:0]          x_next;
  logic [6:0]          y_next;
  logic [COLOUR_W-1:0] colour_next;
  logic                plot_next, busy_next, done_next;

  logic                cnt_start, cnt_en, cnt_last;
  logic [CXW-1:0]      cnt_x;
  logic [CYW-1:0]      cnt_y;

  logic                in_range, moved;

  // The counter always holds the next sweep pixel to emit; it rests at
  // (0,0) outside a sweep, so the entry edge can emit (0,0) directly.
  raster_counter #(
    .W (WIDTH),
    .H (HEIGHT)
  ) u_sweep (
    .clk   (clk),
    .reset (reset),
    .start (cnt_start),
    .en    (cnt_en),
    .x     (cnt_x),
    .y     (cnt_y),
    .last  (cnt_last)
  );

  assign in_range = (int'(xpos) < WIDTH) && (int'(ypos) < HEIGHT);
  assign moved    = redraw || (xpos != last_x) || (ypos != last_y);

  // Next-state and next-output logic. Outputs default to "no write" and
  // the coordinate/colour registers hold their previous values.
  always_comb begin
    state_next  = state;
    last_x_next = last_x;
    last_y_next = last_y;
    redraw_next = redraw;
    x_next      = vga_x;
    y_next      = vga_y;
    colour_next = vga_colour;
    plot_next   = 1'b0;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    cnt_start   = 1'b0;
    cnt_en      = 1'b0;

    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next  = CLEAR;
          plot_next   = 1'b1;
          x_next      = 8'(cnt_x);
          y_next      = 7'(cnt_y);
          colour_next = BG_COLOUR;
          busy_next   = 1'b1;
          cnt_en      = 1'b1;
        end else if (moved) begin
          // Out-of-range positions are still remembered so they do not
          // retrigger every cycle.
          last_x_next = xpos;
          last_y_next = ypos;
          redraw_next = 1'b0;
          if (in_range) begin
            plot_next   = 1'b1;
            x_next      = xpos;
            y_next      = ypos[6:0];
            colour_next = colour_in;
          end
        end
      end

      CLEAR: begin
        plot_next   = 1'b1;
        x_next      = 8'(cnt_x);
        y_next      = 7'(cnt_y);
        colour_next = BG_COLOUR;
        busy_next   = 1'b1;
        if (cnt_last) begin
          state_next = DONE;
          cnt_start  = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      DONE: begin
        state_next  = IDLE;
        busy_next   = 1'b1;
        done_next   = 1'b1;
        last_x_next = xpos;
        last_y_next = ypos;
        redraw_next = 1'b0;
        if (in_range) begin
          plot_next   = 1'b1;
          x_next      = xpos;
          y_next      = ypos[6:0];
          colour_next = colour_in;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. Reset forces a cursor redraw so the
  // pointer reappears as soon as reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RESET_STATE;
      last_x     <= '0;
      last_y     <= '0;
      redraw     <= 1'b1;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      last_x     <= last_x_next;
      last_y     <= last_y_next;
      redraw     <= redraw_next;
      vga_x      <= x_next;
      vga_y      <= y_next;
      vga_colour <= colour_next;
      vga_plot   <= plot_next;
      busy       <= busy_next;
      clear_done <= done_next;
    end
  end

endmodule

// File: tb/tb_plot_ctrl.sv
// tb_plot_ctrl
// Directed bench for plot_ctrl. Stimulus pushes hand-computed expected
// pixel writes (with the cycle they must appear in) onto a queue; a
// separate monitor pops and compares every write the DUT makes, and also
// tracks the expected busy window cycle by cycle.
module tb_plot_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] xpos;
  logic [7:0] ypos;
  logic [2:0] colour_in;
  logic       clear_req;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       clear_done;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       done;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;

  localparam int SWEEP = 160 * 120;

  plot_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .xpos       (xpos),
    .ypos       (ypos),
    .colour_in  (colour_in),
    .clear_req  (clear_req),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .clear_done (clear_done)
  );

  // Free-running clock and a cycle index used to timestamp expectations.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case anything stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Drives one set of inputs on the falling edge.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                               input logic [2:0] c, input logic clr);
    @(negedge clk);
    xpos      = x;
    ypos      = y;
    colour_in = c;
    clear_req = clr;
  endtask

  // Queues one expected write, lat cycles after the current cycle.
  task automatic expectPlot(input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c, input logic done, input int lat);
    exp_t e;
    e.x = x; e.y = y; e.c = c; e.done = done; e.cyc = cyc + lat;
    q.push_back(e);
  endtask

  // Queues a full-or-partial background sweep starting lat cycles from now.
  task automatic expectSweep(input int lat, input int n);
    for (int k = 0; k < n; k++) begin
      expectPlot(8'(k % 160), 7'(k / 160), 3'b000, 1'b0, lat + k);
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] got,
                             input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Monitor: compares busy every cycle and every write against the queue.
  initial begin : monitor
    exp_t e;
    logic exp_busy;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed_plot cyc=%0d exp=(%0d,%0d,c%0d,done%0b)@%0d got=none",
                 cyc, e.x, e.y, e.c, e.done, e.cyc);
      end
      if (vga_plot === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_plot cyc=%0d got=(%0d,%0d,c%0d) exp=none",
                   cyc, vga_x, vga_y, vga_colour);
        end else begin
          e = q.pop_front();
          if (vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c ||
              clear_done !== e.done || cyc != e.cyc) begin
            errors++;
            $display("[TB] FAIL plot cyc=%0d got=(%0d,%0d,c%0d,done%0b) exp=(%0d,%0d,c%0d,done%0b)@%0d",
                     cyc, vga_x, vga_y, vga_colour, clear_done,
                     e.x, e.y, e.c, e.done, e.cyc);
          end
        end
      end else if (clear_done !== 1'b0) begin
        checks++;
        errors++;
        $display("[TB] FAIL stray_done cyc=%0d got=%b exp=0", cyc, clear_done);
      end
    end
  end

  // Directed stimulus.
  initial begin : stimulus
    int c0;
    reset     = 1'b1;
    xpos      = 8'd5;
    ypos      = 8'd7;
    colour_in = 3'b100;
    clear_req = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_plot",   16'(vga_plot),   16'h0);
    checkOutput("rst_x",      16'(vga_x),      16'h0);
    checkOutput("rst_y",      16'(vga_y),      16'h0);
    checkOutput("rst_colour", 16'(vga_colour), 16'h0);
    checkOutput("rst_busy",   16'(busy),       16'h0);
    checkOutput("rst_done",   16'(clear_done), 16'h0);

    // Release: the cursor is redrawn once.
    reset = 1'b0;
    expectPlot(8'd5, 7'd7, 3'b100, 1'b0, 1);
    repeat (4) applyStimulus(8'd5, 8'd7, 3'b100, 1'b0);

    // Single move, then hold.
    applyStimulus(8'd6, 8'd7, 3'b100, 1'b0);
    expectPlot(8'd6, 7'd7, 3'b100, 1'b0, 1);
    repeat (3) applyStimulus(8'd6, 8'd7, 3'b100, 1'b0);

    // Back-to-back moves.
    applyStimulus(8'd7, 8'd7, 3'b010, 1'b0);
    expectPlot(8'd7, 7'd7, 3'b010, 1'b0, 1);
    applyStimulus(8'd8, 8'd8, 3'b010, 1'b0);
    expectPlot(8'd8, 7'd8, 3'b010, 1'b0, 1);
    applyStimulus(8'd9, 8'd9, 3'b011, 1'b0);
    expectPlot(8'd9, 7'd9, 3'b011, 1'b0, 1);

    // Out of range positions produce nothing; the far corner plots.
    applyStimulus(8'd160, 8'd9, 3'b010, 1'b0);
    applyStimulus(8'd160, 8'd9, 3'b010, 1'b0);
    applyStimulus(8'd9, 8'd120, 3'b010, 1'b0);
    applyStimulus(8'd255, 8'd255, 3'b010, 1'b0);
    applyStimulus(8'd159, 8'd119, 3'b101, 1'b0);
    expectPlot(8'd159, 7'd119, 3'b101, 1'b0, 1);
    repeat (3) applyStimulus(8'd159, 8'd119, 3'b101, 1'b0);

    // Full clear from a one-cycle pulse.
    applyStimulus(8'd159, 8'd119, 3'b101, 1'b1);
    c0 = cyc;
    busy_lo = c0 + 1;
    busy_hi = c0 + SWEEP + 1;
    expectSweep(1, SWEEP);
    expectPlot(8'd159, 7'd119, 3'b101, 1'b1, SWEEP + 1);
    while (cyc < c0 + SWEEP + 4) applyStimulus(8'd159, 8'd119, 3'b101, 1'b0);

    // Clear with a move and repeated requests mid-sweep.
    applyStimulus(8'd20, 8'd20, 3'b001, 1'b1);
    c0 = cyc;
    busy_lo = c0 + 1;
    busy_hi = c0 + SWEEP + 1;
    expectSweep(1, SWEEP);
    expectPlot(8'd40, 7'd30, 3'b110, 1'b1, SWEEP + 1);
    repeat (499) applyStimulus(8'd20, 8'd20, 3'b001, 1'b0);
    repeat (10)  applyStimulus(8'd40, 8'd30, 3'b110, 1'b1);
    while (cyc < c0 + SWEEP + 4) applyStimulus(8'd40, 8'd30, 3'b110, 1'b0);

    // Reset right after sweep pixel 1000 is shown.
    applyStimulus(8'd40, 8'd30, 3'b110, 1'b1);
    c0 = cyc;
    busy_lo = c0 + 1;
    busy_hi = c0 + SWEEP + 1;
    expectSweep(1, 1001);
    repeat (1000) applyStimulus(8'd40, 8'd30, 3'b110, 1'b0);
    @(negedge clk);
    reset   = 1'b1;
    busy_hi = cyc;
    @(negedge clk);
    checkOutput("abort_plot", 16'(vga_plot),   16'h0);
    checkOutput("abort_x",    16'(vga_x),      16'h0);
    checkOutput("abort_done", 16'(clear_done), 16'h0);
    checkOutput("abort_busy", 16'(busy),       16'h0);
    reset = 1'b0;
    expectPlot(8'd40, 7'd30, 3'b110, 1'b0, 1);
    repeat (6) applyStimulus(8'd40, 8'd30, 3'b110, 1'b0);

    checkOutput("queue_empty", 16'(q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
